// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus.
// master: pipeline/control side. It drives stall, if_ready and the redirect requests, and it
//         observes the PC outputs.
// slave : the pc_gen block itself.
// Signals:
//   stall, if_ready            pipeline control into the generator
//   br_redirect / br_target    branch or jump redirect (1-cycle pulse)
//   ex_redirect / ex_target    exception or ertn redirect (1-cycle pulse)
//   pc, pc_valid, pc_next      current fetch PC, its legality, and its next value
//   redir_pend, adef           held-redirect flag and sticky misalignment fault
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            stall;
  logic            if_ready;
  logic            br_redirect;
  logic [XLEN-1:0] br_target;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] pc_next;
  logic            redir_pend;
  logic            adef;

  modport master (
    output stall, if_ready, br_redirect, br_target, ex_redirect, ex_target,
    input  pc, pc_valid, pc_next, redir_pend, adef
  );

  modport slave (
    input  stall, if_ready, br_redirect, br_target, ex_redirect, ex_target,
    output pc, pc_valid, pc_next, redir_pend, adef
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
//
// Holds the fetch PC. The PC advances sequentially unless a redirect is taken.
// Redirect priority is: exception, then branch, then a held (pending) redirect, then
// sequential advance. A redirect that arrives while the pipeline is stalled is held
// until the stall drops. A misaligned redirect target raises a sticky ADEF fault.
// The fault is cleared only by an aligned exception redirect.
//
// Ports:
//   clk    clock. All state updates on the falling edge when NEG_EDGE=1,
//          and on the rising edge otherwise.
//   rst_n  asynchronous active-low reset
//   bus    pc_gen_if slave modport (control and redirect inputs, PC outputs)
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INST_BYTES  = 4,
  parameter bit              NEG_EDGE    = 1'b1,
  parameter bit              CHECK_ALIGN = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  localparam logic [XLEN-1:0] Inc = XLEN'(INST_BYTES);

  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;
  typedef enum logic [1:0] {PendNone, PendBr, PendEx} pend_e;

  state_e          state_q, state_d;
  pend_e           pend_kind_q, pend_kind_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            adef_q, adef_d;

  logic            apply;
  logic [XLEN-1:0] tgt;
  logic            misaligned;

  // Active edge select: the falling-edge variant clocks all state from the inverted clock.
  logic act_clk;
  if (NEG_EDGE) begin : g_neg_edge
    assign act_clk = ~clk;
  end else begin : g_pos_edge
    assign act_clk = clk;
  end

  assign misaligned = CHECK_ALIGN && (tgt[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    adef_d      = adef_q;
    apply       = 1'b0;
    tgt         = '0;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        valid_d = 1'b1;
        // Redirects seen during boot are parked and applied once running.
        if (bus.ex_redirect) begin
          pend_kind_d = PendEx;
          pend_tgt_d  = bus.ex_target;
        end else if (bus.br_redirect && pend_kind_q != PendEx) begin
          pend_kind_d = PendBr;
          pend_tgt_d  = bus.br_target;
        end
      end

      StRun: begin
        if (bus.stall) begin
          // A held exception is never displaced by a later branch.
          if (bus.ex_redirect) begin
            pend_kind_d = PendEx;
            pend_tgt_d  = bus.ex_target;
          end else if (bus.br_redirect && pend_kind_q != PendEx) begin
            pend_kind_d = PendBr;
            pend_tgt_d  = bus.br_target;
          end
        end else begin
          if (bus.ex_redirect) begin
            apply = 1'b1;
            tgt   = bus.ex_target;
          end else if (bus.br_redirect) begin
            apply = 1'b1;
            tgt   = bus.br_target;
          end else if (pend_kind_q != PendNone) begin
            apply = 1'b1;
            tgt   = pend_tgt_q;
          end

          if (apply) begin
            // A redirect flushes the fetch, so if_ready does not matter here.
            pend_kind_d = PendNone;
            pend_tgt_d  = '0;
            pc_d        = tgt;
            if (misaligned) begin
              // The bad target stays in pc so the handler can report it as BADV.
              valid_d = 1'b0;
              adef_d  = 1'b1;
              state_d = StFault;
            end
          end else if (bus.if_ready) begin
            pc_d = pc_q + Inc;
          end
        end
      end

      StFault: begin
        if (bus.stall) begin
          if (bus.ex_redirect) begin
            pend_kind_d = PendEx;
            pend_tgt_d  = bus.ex_target;
          end
        end else begin
          if (bus.ex_redirect) begin
            apply = 1'b1;
            tgt   = bus.ex_target;
          end else if (pend_kind_q == PendEx) begin
            apply = 1'b1;
            tgt   = pend_tgt_q;
          end

          if (apply) begin
            pend_kind_d = PendNone;
            pend_tgt_d  = '0;
            pc_d        = tgt;
            if (!misaligned) begin
              valid_d = 1'b1;
              adef_d  = 1'b0;
              state_d = StRun;
            end
          end
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge act_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pend_kind_q <= PendNone;
      pend_tgt_q  <= '0;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      adef_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_tgt_q  <= pend_tgt_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      adef_q      <= adef_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = valid_q;
  assign bus.pc_next    = pc_d;
  assign bus.redir_pend = (pend_kind_q != PendNone);
  assign bus.adef       = adef_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen.
//
// DUT A uses XLEN=32 and updates on the falling edge. Its checking is scoreboard-based:
// every stimulus step pushes the state it expects after the next falling edge, and the
// monitor pops and compares that entry shortly after the edge.
//
// DUT B uses XLEN=16 and updates on the rising edge. It covers the 16-bit wrap-around.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) ifa ();
  pc_gen_if #(.XLEN(16)) ifb ();

  pc_gen #(
    .XLEN(32), .RESET_PC(32'h0), .INST_BYTES(4), .NEG_EDGE(1'b1), .CHECK_ALIGN(1'b1)
  ) dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifa)
  );

  pc_gen #(
    .XLEN(16), .RESET_PC(16'h0), .INST_BYTES(4), .NEG_EDGE(1'b0), .CHECK_ALIGN(1'b1)
  ) dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifb)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        adef;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compares DUT A state shortly after each of its active (falling) edges.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, "/pc"},    ifa.pc,         e.pc);
        chk({e.name, "/valid"}, ifa.pc_valid,   {31'b0, e.valid});
        chk({e.name, "/pend"},  ifa.redir_pend, {31'b0, e.pend});
        chk({e.name, "/adef"},  ifa.adef,       {31'b0, e.adef});
      end
    end
  end

  // One cycle of DUT A stimulus. It drives the inputs mid-cycle and queues the state
  // expected after the coming falling edge. It also checks that pc did not move on the
  // rising edge and that pc_next already predicts the expected pc.
  task automatic step(input string name, input logic st, input logic rdy,
                      input logic br, input logic [31:0] bt,
                      input logic ex, input logic [31:0] et,
                      input logic [31:0] epc, input logic ev, input logic ep,
                      input logic ea);
    exp_t e;
    @(posedge clk);
    #1;
    chk({name, "/hold_posedge"}, ifa.pc, last_pc);
    ifa.stall       = st;
    ifa.if_ready    = rdy;
    ifa.br_redirect = br;
    ifa.br_target   = bt;
    ifa.ex_redirect = ex;
    ifa.ex_target   = et;
    e.name  = name;
    e.pc    = epc;
    e.valid = ev;
    e.pend  = ep;
    e.adef  = ea;
    sb.push_back(e);
    #1;
    chk({name, "/pc_next"}, ifa.pc_next, epc);
    last_pc = epc;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    ifa.stall = 0; ifa.if_ready = 0; ifa.br_redirect = 0; ifa.br_target = '0;
    ifa.ex_redirect = 0; ifa.ex_target = '0;
    ifb.stall = 0; ifb.if_ready = 0; ifb.br_redirect = 0; ifb.br_target = '0;
    ifb.ex_redirect = 0; ifb.ex_target = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset/pc",    ifa.pc,         32'h0);
    chk("reset/valid", ifa.pc_valid,   32'h0);
    chk("reset/pend",  ifa.redir_pend, 32'h0);
    chk("reset/adef",  ifa.adef,       32'h0);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // 1: boot, then sequential advance.
    step("boot",  0, 1, 0, 32'h0, 0, 32'h0, 32'h0,  1, 0, 0);
    step("seq4",  0, 1, 0, 32'h0, 0, 32'h0, 32'h4,  1, 0, 0);
    step("seq8",  0, 1, 0, 32'h0, 0, 32'h0, 32'h8,  1, 0, 0);
    step("seqC",  0, 1, 0, 32'h0, 0, 32'h0, 32'hC,  1, 0, 0);
    step("seq10", 0, 1, 0, 32'h0, 0, 32'h0, 32'h10, 1, 0, 0);
    // 2: branch redirect, and exception winning over a simultaneous branch.
    step("br100",    0, 0, 1, 32'h100, 0, 32'h0,   32'h100, 1, 0, 0);
    step("ex_vs_br", 0, 0, 1, 32'h300, 1, 32'h200, 32'h200, 1, 0, 0);
    step("hold_rdy", 0, 0, 0, 32'h0,   0, 32'h0,   32'h200, 1, 0, 0);
    // 3: redirects held during a stall; the exception is not displaced by a later branch.
    step("st_br40",  1, 1, 1, 32'h40, 0, 32'h0,  32'h200, 1, 1, 0);
    step("st_ex80",  1, 1, 0, 32'h0,  1, 32'h80, 32'h200, 1, 1, 0);
    step("st_brC0",  1, 1, 1, 32'hC0, 0, 32'h0,  32'h200, 1, 1, 0);
    step("unstall",  0, 1, 0, 32'h0,  0, 32'h0,  32'h80,  1, 0, 0);
    step("seq84",    0, 1, 0, 32'h0,  0, 32'h0,  32'h84,  1, 0, 0);
    // 4: misaligned target enters FAULT; branch ignored; exception recovers.
    step("br_mis",   0, 0, 1, 32'h102, 0, 32'h0,        32'h102,      0, 0, 1);
    step("flt_br",   0, 1, 1, 32'h200, 0, 32'h0,        32'h102,      0, 0, 1);
    step("flt_ex",   0, 0, 0, 32'h0,   1, 32'h1C000000, 32'h1C000000, 1, 0, 0);
    step("br_mis3",  0, 0, 1, 32'h3,   0, 32'h0,        32'h3,        0, 0, 1);
    step("flt_stex", 1, 0, 0, 32'h0,   1, 32'h500,      32'h3,        0, 1, 1);
    step("flt_rel",  0, 0, 0, 32'h0,   0, 32'h0,        32'h500,      1, 0, 0);
    // 5: 32-bit wrap.
    step("br_top",   0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 32'hFFFFFFFC, 1, 0, 0);
    step("wrap",     0, 1, 0, 32'h0,        0, 32'h0, 32'h0,        1, 0, 0);
    step("seq4b",    0, 1, 0, 32'h0,        0, 32'h0, 32'h4,        1, 0, 0);
    // 6: asynchronous reset while a redirect is held.
    step("st_br700", 1, 0, 1, 32'h700, 0, 32'h0, 32'h4, 1, 1, 0);
    @(negedge clk);
    #3 ifa.br_redirect = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst/pc",    ifa.pc,         32'h0);
    chk("async_rst/pend",  ifa.redir_pend, 32'h0);
    chk("async_rst/valid", ifa.pc_valid,   32'h0);
    ifa.stall = 0;
    last_pc = 32'h0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    step("reboot",   0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 0);
    step("no_stale", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 0);
    step("seq4c",    0, 1, 0, 32'h0, 0, 32'h0, 32'h4, 1, 0, 0);
    @(negedge clk);
    #3 ifa.if_ready = 0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #3;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    // 16-bit wrap on the rising-edge instance (already running since the reset release).
    @(negedge clk);
    #1 ifb.br_redirect = 1; ifb.br_target = 16'hFFF8;
    @(posedge clk);
    #2 chk("b_br/pc", {16'h0, ifb.pc}, 32'hFFF8);
    @(negedge clk);
    #1 ifb.br_redirect = 0; ifb.if_ready = 1;
    @(posedge clk);
    #2 chk("b_seq/pc", {16'h0, ifb.pc}, 32'hFFFC);
    @(posedge clk);
    #2;
    chk("b_wrap/pc",    {16'h0, ifb.pc}, 32'h0);
    chk("b_wrap/valid", ifb.pc_valid,    32'h1);
    chk("b_wrap/adef",  ifb.adef,        32'h0);
    ifb.if_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
